// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the scoreboarded integer register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned REG_AW    = $clog2(NREGS_DEF);

   // Architectural register index at the default register count
   typedef logic [REG_AW-1:0] reg_idx_t;

   // Hardwired-zero register: never written, never busy
   localparam int unsigned ZERO_REG = 0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one outstanding-producer bit per register plus a running busy count.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned NWR   = 1,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NWR-1:0]          wr_en,
   input  logic [NWR-1:0][AW-1:0]  wr_addr,
   input  logic                    iss_en,
   input  logic [AW-1:0]           iss_addr,
   output logic [NREGS-1:0]        busy,
   output logic [AW:0]             busy_cnt
);

   localparam int unsigned CW = AW + 1;

   logic [NREGS-1:0] clr_mask;
   logic [NREGS-1:0] set_mask;
   logic [NREGS-1:0] busy_nxt;
   logic [NREGS-1:0] rise;
   logic [NREGS-1:0] fall;
   logic [CW-1:0]    n_set;
   logic [CW-1:0]    n_clr;
   logic [CW-1:0]    cnt_nxt;

   // Next busy vector: a new issue overrides a same-cycle writeback clear
   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      for (int p = 0; p < NWR; p++) begin
         if (wr_en[p]) clr_mask[wr_addr[p]] = 1'b1;
      end
      if (iss_en) set_mask[iss_addr] = 1'b1;
      set_mask[ZERO_REG] = 1'b0;
      busy_nxt = (busy & ~clr_mask) | set_mask;
      rise     = busy_nxt & ~busy;
      fall     = busy & ~busy_nxt;
      n_set    = '0;
      n_clr    = '0;
      for (int i = 0; i < NREGS; i++) begin
         n_set = n_set + CW'(rise[i]);
         n_clr = n_clr + CW'(fall[i]);
      end
      cnt_nxt = busy_cnt + n_set - n_clr;
   end

   // Busy bits and count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

endmodule : regfile_scoreboard

// File: rtl/sb_register_file.sv
// Multi-port integer register file with busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module sb_register_file
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned NRD   = 2,
   parameter int unsigned NWR   = 1,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NRD-1:0][AW-1:0]   rd_addr,
   output logic [NRD-1:0][XLEN-1:0] rd_data,
   output logic [NRD-1:0]           rd_busy,
   input  logic [NWR-1:0]           wr_en,
   input  logic [NWR-1:0][AW-1:0]   wr_addr,
   input  logic [NWR-1:0][XLEN-1:0] wr_data,
   input  logic                     iss_en,
   input  logic [AW-1:0]            iss_addr,
   output logic [AW:0]              busy_cnt
);

   logic [NREGS-1:0][XLEN-1:0] regs;
   logic [NREGS-1:0]           busy;

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy     (busy),
      .busy_cnt (busy_cnt)
   );

   // Data array writes; later ports overwrite earlier ones on an address collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p] != AW'(ZERO_REG))) regs[wr_addr[p]] <= wr_data[p];
         end
      end
   end

   // Combinational read ports, optionally forwarding the writeback in flight
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd_data[i] = regs[rd_addr[i]];
         rd_busy[i] = busy[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
         for (int p = 0; p < NWR; p++) begin
            if (rst_n && wr_en[p] && (wr_addr[p] == rd_addr[i]) &&
                (rd_addr[i] != AW'(ZERO_REG))) begin
               rd_data[i] = wr_data[p];
               rd_busy[i] = 1'b0;
            end
         end
`endif
      end
   end

endmodule : sb_register_file

// File: tb/tb_sb_register_file.sv
// Directed self-checking bench for sb_register_file (NRD=2, NWR=2).
module tb_sb_register_file;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NRD   = 2;
   localparam int unsigned NWR   = 2;
   localparam int unsigned AW    = 5;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NRD-1:0][AW-1:0]   rd_addr;
   logic [NRD-1:0][XLEN-1:0] rd_data;
   logic [NRD-1:0]           rd_busy;
   logic [NWR-1:0]           wr_en;
   logic [NWR-1:0][AW-1:0]   wr_addr;
   logic [NWR-1:0][XLEN-1:0] wr_data;
   logic                     iss_en;
   logic [AW-1:0]            iss_addr;
   logic [AW:0]              busy_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   sb_register_file #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic idle();
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b1;
      rd_addr = '0;
      idle();
      #1 rst_n = 1'b0;
      rd_addr[0] = 5'd5;
      #1;
      tests_run++;
      if (rd_data[0] !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h expected %h", rd_data[0], 32'h0);
      end
      tests_run++;
      if (busy_cnt !== 6'd0) begin
         tests_failed++;
         $display("FAIL reset_cnt: got %0d expected 0", busy_cnt);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_run();
      wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
      iss_en = 1'b1; iss_addr = 5'd7;
      step();
      idle();
      rd_addr[0] = 5'd5; rd_addr[1] = 5'd7;
      #1;
      tests_run++;
      if (rd_data[0] !== 32'hDEADBEEF || rd_busy[1] !== 1'b1 || busy_cnt !== 6'd1) begin
         tests_failed++;
         $display("FAIL pre_reset_state: got data %h busy %b cnt %0d expected deadbeef 1 1",
                  rd_data[0], rd_busy[1], busy_cnt);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (rd_data[0] !== 32'h0) begin
         tests_failed++;
         $display("FAIL async_reset_data: got %h expected 0", rd_data[0]);
      end
      tests_run++;
      if (rd_busy[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset_busy: got %b expected 0", rd_busy[1]);
      end
      tests_run++;
      if (busy_cnt !== 6'd0) begin
         tests_failed++;
         $display("FAIL async_reset_cnt: got %0d expected 0", busy_cnt);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_zero_reg();
      wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
      iss_en = 1'b1; iss_addr = 5'd0;
      rd_addr[0] = 5'd0;
      #1;
      tests_run++;
      if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL x0_same_cycle: got %h busy %b expected 0 0", rd_data[0], rd_busy[0]);
      end
      step();
      idle();
      #1;
      tests_run++;
      if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0) begin
         tests_failed++;
         $display("FAIL x0_after: got %h busy %b cnt %0d expected 0 0 0",
                  rd_data[0], rd_busy[0], busy_cnt);
      end
   endtask

   task automatic test_write_priority();
      logic [XLEN-1:0] exp_now;
      wr_en = 2'b11;
      wr_addr[0] = 5'd3; wr_data[0] = 32'h11;
      wr_addr[1] = 5'd3; wr_data[1] = 32'h22;
      rd_addr[0] = 5'd3;
`ifdef REGFILE_BYPASS_EN
      exp_now = 32'h22;
`else
      exp_now = 32'h0;
`endif
      #1;
      tests_run++;
      if (rd_data[0] !== exp_now) begin
         tests_failed++;
         $display("FAIL dual_write_same_cycle: got %h expected %h", rd_data[0], exp_now);
      end
      step();
      idle();
      #1;
      tests_run++;
      if (rd_data[0] !== 32'h22 || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0) begin
         tests_failed++;
         $display("FAIL dual_write_winner: got %h busy %b cnt %0d expected 22 0 0",
                  rd_data[0], rd_busy[0], busy_cnt);
      end
   endtask

   task automatic test_issue_write_same();
      iss_en = 1'b1; iss_addr = 5'd4;
      rd_addr[0] = 5'd4;
      step();
      idle();
      #1;
      tests_run++;
      if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
         tests_failed++;
         $display("FAIL issue_x4: got busy %b cnt %0d expected 1 1", rd_busy[0], busy_cnt);
      end
      wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h1234;
      iss_en = 1'b1; iss_addr = 5'd4;
      step();
      idle();
      #1;
      tests_run++;
      if (rd_busy[0] !== 1'b1 || rd_data[0] !== 32'h1234 || busy_cnt !== 6'd1) begin
         tests_failed++;
         $display("FAIL issue_wins_over_write: got busy %b data %h cnt %0d expected 1 1234 1",
                  rd_busy[0], rd_data[0], busy_cnt);
      end
      wr_en[1] = 1'b1; wr_addr[1] = 5'd4; wr_data[1] = 32'h1234;
      step();
      idle();
      #1;
      tests_run++;
      if (rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0) begin
         tests_failed++;
         $display("FAIL clear_x4: got busy %b cnt %0d expected 0 0", rd_busy[0], busy_cnt);
      end
   endtask

   task automatic test_busy_count();
      for (int r = 1; r <= 3; r++) begin
         iss_en = 1'b1; iss_addr = AW'(r);
         step();
         idle();
         #1;
         tests_run++;
         if (busy_cnt !== 6'(r)) begin
            tests_failed++;
            $display("FAIL cnt_after_issue_%0d: got %0d expected %0d", r, busy_cnt, r);
         end
      end
      iss_en = 1'b1; iss_addr = 5'd1;
      step();
      idle();
      #1;
      tests_run++;
      if (busy_cnt !== 6'd3) begin
         tests_failed++;
         $display("FAIL reissue_busy: got %0d expected 3", busy_cnt);
      end
      wr_en[0] = 1'b1; wr_addr[0] = 5'd2; wr_data[0] = 32'h55;
      rd_addr[0] = 5'd2; rd_addr[1] = 5'd1;
      step();
      idle();
      #1;
      tests_run++;
      if (busy_cnt !== 6'd2 || rd_busy[0] !== 1'b0 || rd_busy[1] !== 1'b1 || rd_data[0] !== 32'h55) begin
         tests_failed++;
         $display("FAIL writeback_x2: got cnt %0d busy %b%b data %h expected 2 10 55",
                  busy_cnt, rd_busy[1], rd_busy[0], rd_data[0]);
      end
      wr_en = 2'b11; wr_addr[0] = 5'd1; wr_addr[1] = 5'd3;
      step();
      idle();
      #1;
      tests_run++;
      if (busy_cnt !== 6'd0) begin
         tests_failed++;
         $display("FAIL dual_clear: got %0d expected 0", busy_cnt);
      end
   endtask

   task automatic test_full_scoreboard();
      for (int r = 1; r < NREGS; r++) begin
         iss_en = 1'b1; iss_addr = AW'(r);
         step();
      end
      idle();
      rd_addr[0] = 5'd31; rd_addr[1] = 5'd0;
      #1;
      tests_run++;
      if (busy_cnt !== 6'd31 || rd_busy[0] !== 1'b1 || rd_busy[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL all_busy: got cnt %0d busy31 %b busy0 %b expected 31 1 0",
                  busy_cnt, rd_busy[0], rd_busy[1]);
      end
      for (int r = 1; r < NREGS; r += 2) begin
         wr_en[0] = 1'b1; wr_addr[0] = AW'(r);
         wr_en[1] = (r + 1 < NREGS); wr_addr[1] = AW'(r + 1);
         step();
      end
      idle();
      #1;
      tests_run++;
      if (busy_cnt !== 6'd0 || rd_busy[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL all_cleared: got cnt %0d busy31 %b expected 0 0", busy_cnt, rd_busy[0]);
      end
   endtask

   task automatic test_bypass();
      logic [XLEN-1:0] exp_data;
      logic            exp_busy;
      wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h1;
      step();
      idle();
      iss_en = 1'b1; iss_addr = 5'd9;
      step();
      idle();
      wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'hCAFE;
      rd_addr[0] = 5'd9;
`ifdef REGFILE_BYPASS_EN
      exp_data = 32'hCAFE; exp_busy = 1'b0;
`else
      exp_data = 32'h1;    exp_busy = 1'b1;
`endif
      #1;
      tests_run++;
      if (rd_data[0] !== exp_data || rd_busy[0] !== exp_busy) begin
         tests_failed++;
         $display("FAIL x9_same_cycle: got %h busy %b expected %h %b",
                  rd_data[0], rd_busy[0], exp_data, exp_busy);
      end
      step();
      idle();
      #1;
      tests_run++;
      if (rd_data[0] !== 32'hCAFE || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0) begin
         tests_failed++;
         $display("FAIL x9_next_cycle: got %h busy %b cnt %0d expected cafe 0 0",
                  rd_data[0], rd_busy[0], busy_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_run();
      test_zero_reg();
      test_write_priority();
      test_issue_write_same();
      test_busy_count();
      test_full_scoreboard();
      test_bypass();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_sb_register_file

// File: doc/sb_register_file.md
# sb_register_file

Parametrised multi-port integer register file with a per-register busy scoreboard, the next generation of the core's architectural register storage. It supplies operands to decode/issue from NRD combinational read ports, accepts results from NWR writeback ports, and tracks which registers have an outstanding producer so issue logic can detect RAW hazards. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports (≥ 1)
- NWR, 1, number of write ports (≥ 1)
- AW, $clog2(NREGS), address width (derived, do not override)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×XLEN  read data, combinational
- rd_busy  out  NRD  register has an outstanding producer, combinational
- wr_en  in  NWR  write strobes
- wr_addr  in  NWR×AW  write addresses
- wr_data  in  NWR×XLEN  write data
- iss_en  in  1  mark iss_addr busy (instruction issued with this destination)
- iss_addr  in  AW  destination being issued
- busy_cnt  out  AW+1  number of registers currently busy, registered

## Operation
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, busy_cnt 0; rd_data reads 0 and rd_busy 0 while held in reset.
- Write: at rising edge, for each port p with wr_en[p] and wr_addr[p] ≠ 0, register ← wr_data[p]. Several ports to same address in one cycle: highest-indexed port wins.
- Writes to register 0 ignored; register 0 always reads 0, rd_busy 0; iss_addr 0 ignored.
- Busy clear: any write-enabled port to address A clears busy[A].
- Busy set: iss_en with iss_addr ≠ 0 sets busy[iss_addr]. Issue and write to same address in same cycle: busy stays/becomes 1 (new producer wins).
- Issue to an already-busy register: stays busy (single bit, no count per register).
- Write to a non-busy register: legal, data updated, busy unchanged at 0.
- busy_cnt: registered popcount of busy bits, updated each edge as next = current + sets − clears; never exceeds NREGS − 1.
- Reads: rd_data[i] = register[rd_addr[i]], rd_busy[i] = busy[rd_addr[i]] (subject to Configuration).

## Timing
- Write latency: 1 cycle; data visible on reads the cycle after the write edge (without bypass).
- Busy set/clear visible on rd_busy the cycle after the edge.
- Read ports purely combinational from address to data; no read latency.
- busy_cnt reflects state after the most recent edge.
- Reset deassertion: first write/issue honoured on the first rising edge with rst_n high.

## Configuration
- REGFILE_BYPASS_EN defined: if any wr_en[p] matches rd_addr[i] ≠ 0 this cycle, rd_data[i] = wr_data of highest such p and rd_busy[i] = 0 (result forwarded in writeback cycle). A same-cycle issue to that address does not affect the current read.
- Undefined: reads return stored state only; same-cycle write not visible until next cycle.

## Structure
- Package regfile_pkg: XLEN default, NREGS default, reg index typedef, ZERO_REG constant.
- Sub-module regfile_scoreboard: busy bit vector, set/clear priority, busy_cnt counter; top holds data array, write priority, read muxes and bypass.

## Test plan
- Reset mid-run after writing x5=0xDEADBEEF and issuing x7: assert rst_n=0 -> rd_data x5 = 0, rd_busy x7 = 0, busy_cnt = 0 immediately, without clock edge.
- Write x0=0xFFFFFFFF, iss_addr=0 -> x0 reads 0, rd_busy 0, busy_cnt 0.
- NWR=2, both ports write x3 (0x11, 0x22) same cycle -> next cycle x3 reads 0x22.
- Issue x4, then next cycle write x4=0x1234 and issue x4 simultaneously -> rd_busy x4 = 1, data 0x1234, busy_cnt 1.
- Issue x1,x2,x3 on consecutive cycles, then write x2 -> busy_cnt 1,2,3,2.
- Write x9=0xCAFE while reading x9: with REGFILE_BYPASS_EN rd_data=0xCAFE, rd_busy=0 same cycle; without, old value same cycle, 0xCAFE next cycle.
